// File: rtl/axis_pkg.sv
// Shared defaults and stored-entry layout for the AXI-Stream packet FIFO.
package axis_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    typedef struct packed {
        logic                  last;
        logic [DATA_W_DEF-1:0] data;
    } axis_entry_t;

endpackage

// File: rtl/axis_fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous read.
module axis_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// First-word-fall-through AXI-Stream FIFO with word and packet counts.
// Define AXIS_PKT_FIFO_STORE_FWD_EN to hold output until a whole packet is stored.
module axis_pkt_fifo
    import axis_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     K_tvalid,
    input  logic                     K_tlast,
    input  logic [DATA_W-1:0]        K_tdata,
    output logic                     K_tready,
    output logic                     M_tvalid,
    output logic                     M_tlast,
    output logic [DATA_W-1:0]        M_tdata,
    input  logic                     M_tready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   pkt_count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic [AW:0]     r_count;
    logic [AW:0]     r_pkt_count;
    logic            r_rst_q;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;
    logic            w_push_last;
    logic            w_pop_last;
    logic [DATA_W:0] w_rd_word;

    axis_fifo_mem #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata ({K_tlast, K_tdata}),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rd_word)
    );

    // Extra pointer MSB tells a full ring from an empty one.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign K_tready    = ~r_rst_q & ~w_full;
    assign w_push      = K_tvalid & K_tready;
    assign w_pop       = w_valid & M_tready;
    assign w_push_last = w_push & K_tlast;
    assign w_pop_last  = w_pop & w_rd_word[DATA_W];

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
    logic r_mid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mid <= 1'b0;
        end else if (w_pop) begin
            r_mid <= ~w_rd_word[DATA_W];
        end
    end

    // A full FIFO with no complete packet releases as cut-through to avoid deadlock.
    assign w_valid = ~w_empty & ((r_pkt_count != '0) | r_mid | w_full);
`else
    assign w_valid = ~w_empty;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pkt_count <= '0;
            r_rst_q     <= 1'b1;
        end else begin
            r_rst_q <= 1'b0;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            case ({w_push_last, w_pop_last})
                2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
                2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
                default: r_pkt_count <= r_pkt_count;
            endcase
        end
    end

    assign M_tvalid  = w_valid;
    assign M_tlast   = w_valid & w_rd_word[DATA_W];
    assign M_tdata   = w_valid ? w_rd_word[DATA_W-1:0] : '0;
    assign count     = r_count;
    assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Randomized and directed bench for axis_pkt_fifo against a queue-based model.
// Honours AXIS_PKT_FIFO_STORE_FWD_EN when defined for the build.
module tb_axis_pkt_fifo;
    import axis_pkg::*;

    localparam int DW = DATA_W_DEF;
    localparam int DP = DEPTH_DEF;

    logic          clk = 1'b0;
    logic          reset;
    logic          K_tvalid;
    logic          K_tlast;
    logic [DW-1:0] K_tdata;
    logic          K_tready;
    logic          M_tvalid;
    logic          M_tlast;
    logic [DW-1:0] M_tdata;
    logic          M_tready;
    logic [$clog2(DP):0] count;
    logic [$clog2(DP):0] pkt_count;

    axis_pkt_fifo #(
        .DATA_W (DW),
        .DEPTH  (DP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .K_tvalid  (K_tvalid),
        .K_tlast   (K_tlast),
        .K_tdata   (K_tdata),
        .K_tready  (K_tready),
        .M_tvalid  (M_tvalid),
        .M_tlast   (M_tlast),
        .M_tdata   (M_tdata),
        .M_tready  (M_tready),
        .count     (count),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    axis_entry_t q[$];
    bit          m_rst;
    bit          m_mid;
    int unsigned n_chk;
    int unsigned n_fail;
    int unsigned n_pop;

    function automatic int m_pkts();
        int n = 0;
        foreach (q[i]) if (q[i].last) n++;
        return n;
    endfunction

    function automatic bit m_valid();
        if (q.size() == 0) return 1'b0;
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
        return (m_pkts() > 0) || m_mid || (q.size() == DP);
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit m_ready();
        return !m_rst && (q.size() < DP);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("count", 32'(count), 32'(q.size()));
        check("pkt_count", 32'(pkt_count), 32'(m_pkts()));
        check("K_tready", 32'(K_tready), 32'(m_ready()));
        check("M_tvalid", 32'(M_tvalid), 32'(m_valid()));
        if (m_valid()) begin
            check("M_tdata", 32'(M_tdata), 32'(q[0].data));
            check("M_tlast", 32'(M_tlast), 32'(q[0].last));
        end
        if (m_rst) begin
            check("rst_M_tdata", 32'(M_tdata), 32'd0);
            check("rst_M_tlast", 32'(M_tlast), 32'd0);
        end
    endtask

    // Checks current outputs, applies one cycle of stimulus, then advances the model.
    task automatic cycle(input logic rst_n, input logic kv, input logic kl,
                         input logic [DW-1:0] kd, input logic mr);
        bit          do_push;
        bit          do_pop;
        axis_entry_t e;
        check_outputs();
        reset    = rst_n;
        K_tvalid = kv;
        K_tlast  = kl;
        K_tdata  = kd;
        M_tready = mr;
        do_push  = kv && m_ready();
        do_pop   = mr && m_valid();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            m_rst = 1'b1;
            m_mid = 1'b0;
        end else begin
            m_rst = 1'b0;
            if (do_pop) begin
                e = q.pop_front();
                m_mid = !e.last;
                n_pop++;
            end
            if (do_push) begin
                e.last = kl;
                e.data = kd;
                q.push_back(e);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() > 0; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("drain_count", 32'(count), 32'd0);
        check("drain_valid", 32'(M_tvalid), 32'd0);
    endtask

    initial begin
        int unsigned sent;
        int unsigned pop_base;
        int unsigned bias;
        bit          acc;

        n_chk = 0; n_fail = 0; n_pop = 0; m_mid = 1'b0;
        reset = 1'b0; K_tvalid = 1'b0; K_tlast = 1'b0; K_tdata = '0; M_tready = 1'b0;
        @(posedge clk);
        #1;
        m_rst = 1'b1;
        check("reset_K_tready", 32'(K_tready), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);

        // Basic: four 0x0F words, tlast on the fourth
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, i == 3, 8'h0F, 1'b1);
        drain();

        // Full
        for (int i = 0; i < 17; i++) cycle(1'b1, 1'b1, i == 15, 8'(i + 8'h30), 1'b0);
        check("full_count", 32'(count), 32'd16);
        check("full_ready", 32'(K_tready), 32'd0);
        drain();

        // Simultaneous push/pop at count 8
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, (i % 4) == 3, 8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, (i % 4) == 3, 8'(8'hA0 + i), 1'b1);
        check("simul_count", 32'(count), 32'd8);
        drain();

        // Store-forward: three words without tlast, then tlast
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 8'h55, 1'b0);
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
        check("sf_hold", 32'(M_tvalid), 32'd0);
`else
        check("ct_valid", 32'(M_tvalid), 32'd1);
`endif
        cycle(1'b1, 1'b1, 1'b1, 8'h55, 1'b0);
        check("sf_valid", 32'(M_tvalid), 32'd1);
        check("sf_pkt", 32'(pkt_count), 32'd1);
        drain();

        // Oversize 20-word packet
        pop_base = n_pop;
        sent = 0;
        for (int i = 0; i < 100 && sent < 20; i++) begin
            acc = m_ready();
            cycle(1'b1, 1'b1, sent == 19, 8'(sent), 1'b1);
            if (acc) sent++;
        end
        drain();
        check("oversize_words", n_pop - pop_base, 32'd20);

        // Reset mid-packet
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        check("pre_rst_count", 32'(count), 32'd5);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_pkt", 32'(pkt_count), 32'd0);
        check("post_rst_valid", 32'(M_tvalid), 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 8'hD1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 8'hD2, 1'b0);
        drain();

        // Randomized traffic with shifting backpressure and rare resets
        bias = 50;
        for (int i = 0; i < 900; i++) begin
            if (i % 100 == 0) bias = ($urandom_range(0, 2) == 0) ? 15 : (($urandom_range(0, 1) == 0) ? 50 : 90);
            cycle($urandom_range(0, 149) != 0, ($urandom % 4) != 0, ($urandom % 5) == 0,
                  8'($urandom), $urandom_range(0, 99) < bias);
        end
        sent = 0;
        for (int i = 0; i < 60 && sent == 0; i++) begin
            acc = m_ready();
            cycle(1'b1, 1'b1, 1'b1, 8'hEE, 1'b1);
            if (acc) sent = 1;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_pkt_fifo.md
AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the tdata width.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the number of entries (power of 2, at least 4).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 K_tvalid  input  1  upstream (arbiter output) word valid.
REQ-006 K_tlast  input  1  upstream end-of-packet marker.
REQ-007 K_tdata  input  DATA_W  upstream data.
REQ-008 K_tready  output  1  FIFO accepts an upstream word.
REQ-009 M_tvalid  output  1  downstream word valid.
REQ-010 M_tlast  output  1  downstream end-of-packet marker.
REQ-011 M_tdata  output  DATA_W  downstream data.
REQ-012 M_tready  input  1  downstream accepts a word.
REQ-013 count  output  log2(DEPTH)+1  stored word count.
REQ-014 pkt_count  output  log2(DEPTH)+1  stored complete packets (words with tlast).

Function
REQ-015 A push SHALL occur when K_tvalid and K_tready are both 1; {tlast, tdata} is written at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-016 A pop SHALL occur when M_tvalid and M_tready are both 1; rd_ptr increments modulo DEPTH.
REQ-017 K_tready SHALL be 1 exactly when count < DEPTH; it does not depend on M_tready in the same cycle (no pass-through when full).
REQ-018 Output SHALL be first-word-fall-through: M_tdata and M_tlast reflect the entry at rd_ptr, and a word pushed in cycle N is visible no earlier than cycle N+1.
REQ-019 The output SHALL hold M_tvalid, M_tdata and M_tlast stable while M_tvalid=1 and M_tready=0.
REQ-020 count SHALL update by +1 on a push only, -1 on a pop only, and stay unchanged on a simultaneous push and pop; it never exceeds DEPTH or goes below 0.
REQ-021 pkt_count SHALL increment on a push with K_tlast=1 and decrement on a pop with M_tlast=1; both in the same cycle leaves it unchanged.
REQ-022 Pointers SHALL be log2(DEPTH)+1 bits wide; full and empty are distinguished by the MSB, and wrap-around is seamless.
REQ-023 When empty, M_tvalid SHALL be 0 and no pop occurs, regardless of M_tready.
REQ-024 Words SHALL leave in arrival order, and tlast is preserved per word.

Reset
REQ-025 When reset=0 at a clock edge, the block SHALL clear wr_ptr, rd_ptr, count and pkt_count to 0, and drive M_tvalid=0, M_tlast=0, M_tdata=0, K_tready=0.
REQ-026 K_tready SHALL be 1 from the first edge after reset returns to 1.
REQ-027 Reset mid-packet SHALL discard all stored words; memory contents need not be cleared.

Configuration
REQ-028 With macro AXIS_PKT_FIFO_STORE_FWD_EN defined, M_tvalid SHALL be 1 only when pkt_count>0, or when the FIFO is mid-packet on output (a word of the current output packet has already been popped), or when count==DEPTH and pkt_count==0.
REQ-029 The count==DEPTH, pkt_count==0 case is the oversize-packet escape and SHALL fall back to cut-through until that packet's tlast is popped.
REQ-030 Without the macro, M_tvalid SHALL be 1 whenever count>0 (cut-through).

Structure
REQ-031 Package axis_pkg SHALL hold DATA_W_DEF=8, DEPTH_DEF=16, and the typedef for the stored entry {last, data}.
REQ-032 Storage SHALL be a sub-module axis_fifo_mem with synchronous write and asynchronous read, DEPTH x (DATA_W+1) bits; pointers, counters and valid logic live in axis_pkt_fifo.

Verification
REQ-033 Basic: push 4 words 0x0F with tlast on the 4th while M_tready=1 -> 4 words out in order, M_tlast only on the 4th, each word out at the earliest 1 cycle after its push.
REQ-034 Full: M_tready=0, push 17 words -> K_tready=0 after the 16th push, count=16, 17th word not accepted; M_tready=1 -> 16 words drained, count=0, M_tvalid=0.
REQ-035 Simultaneous: count=8, push and pop every cycle for 20 cycles -> count stays 8, pointers wrap, data order intact.
REQ-036 Store-forward (macro on): push 3 words 0x55 without tlast -> M_tvalid=0; push a 4th with tlast -> M_tvalid=1 next cycle, pkt_count=1. With the macro off, M_tvalid=1 one cycle after the first push.
REQ-037 Oversize (macro on): 20-word packet with M_tready=1 -> at count=16 output starts, all 20 words delivered, tlast on the 20th, no deadlock.
REQ-038 Reset mid-packet: hold reset=0 for 1 edge with count=5 -> next cycle count=0, pkt_count=0, M_tvalid=0, and a new packet flows normally.
